// File: rtl/csr_io_pkg.sv
// Shared CSR numbers, access type and request payload for the CSR I/O unit.
package csr_io_pkg;

    localparam int unsigned CSR_NUM_W  = 12;
    localparam int unsigned CSR_DATA_W = 32;

    localparam logic [CSR_NUM_W-1:0] CSR_IN_BASE  = 12'hFC2;
    localparam logic [CSR_NUM_W-1:0] CSR_OUT_BASE = 12'h7C2;
    localparam logic [CSR_NUM_W-1:0] CSR_STATUS   = 12'hFC1;
    localparam logic [CSR_NUM_W-1:0] CSR_CYCLE    = 12'hC00;

    typedef enum logic {
        CSR_READ  = 1'b0,
        CSR_WRITE = 1'b1
    } csr_type_t;

    typedef struct packed {
        logic                  val;
        csr_type_t             kind;
        logic [CSR_NUM_W-1:0]  num;
        logic [CSR_DATA_W-1:0] wdata;
    } csr_req_t;

endpackage

// File: rtl/csr_io_fifo.sv
// Output-channel FIFO: DEPTH entries, head visible the cycle after a push.
module csr_io_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         val,
    output logic [W-1:0] head,
    output logic         full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_en;
    logic          pop_en;

    assign val     = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign pop_en  = pop && val;
    assign push_en = push && (!full || pop_en);

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/csr_io_unit.sv
// CSR I/O unit: csrr/csrw access to NCHAN input capture registers and NCHAN output FIFOs.
// Optional cycle counter at CSR 0xC00 enabled by defining CSR_IO_CYCLE_COUNTER_EN.
module csr_io_unit
    import csr_io_pkg::*;
#(
    parameter int unsigned NCHAN = 3,
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_val,
    input  logic               csr_type,
    input  logic [11:0]        csr_num,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_stall,
    input  logic [NCHAN-1:0]   in_val,
    output logic [NCHAN-1:0]   in_rdy,
    input  logic [NCHAN*W-1:0] in_data,
    output logic [NCHAN-1:0]   out_val,
    input  logic [NCHAN-1:0]   out_rdy,
    output logic [NCHAN*W-1:0] out_data
);

    csr_req_t         req;
    logic             is_rd;
    logic             is_wr;
    logic [NCHAN-1:0] rd_in_hit;
    logic [NCHAN-1:0] wr_out_hit;
    logic [NCHAN-1:0] stall_vec;
    logic [NCHAN-1:0] push;
    logic [NCHAN-1:0] fifo_full;
    logic [NCHAN-1:0] fresh;
    logic [W-1:0]     in_reg [NCHAN];
    logic [31:0]      status;

    assign req   = '{val: csr_val, kind: csr_type_t'(csr_type), num: csr_num, wdata: csr_wdata};
    assign is_rd = req.val && (req.kind == CSR_READ);
    assign is_wr = req.val && (req.kind == CSR_WRITE);

    assign csr_stall = |stall_vec;

    for (genvar i = 0; i < int'(NCHAN); i++) begin : g_chan
        assign rd_in_hit[i]  = is_rd && (req.num == CSR_IN_BASE + 12'(i));
        assign wr_out_hit[i] = is_wr && (req.num == CSR_OUT_BASE + 12'(i));
        assign in_rdy[i]     = !fresh[i] || rd_in_hit[i];
        // A full FIFO still accepts the write when its head leaves this cycle.
        assign stall_vec[i]  = wr_out_hit[i] && fifo_full[i] && !out_rdy[i];
        assign push[i]       = wr_out_hit[i] && !csr_stall;

        csr_io_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_data (req.wdata[W-1:0]),
            .pop       (out_rdy[i]),
            .val       (out_val[i]),
            .head      (out_data[i*W +: W]),
            .full      (fifo_full[i])
        );
    end

    // Input capture registers; a same-cycle transfer wins over the read's clear of fresh.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fresh <= '0;
            for (int i = 0; i < int'(NCHAN); i++) begin
                in_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NCHAN); i++) begin
                if (in_val[i] && in_rdy[i]) begin
                    in_reg[i] <= in_data[i*W +: W];
                    fresh[i]  <= 1'b1;
                end else if (rd_in_hit[i]) begin
                    fresh[i]  <= 1'b0;
                end
            end
        end
    end

`ifdef CSR_IO_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (is_wr && (req.num == CSR_CYCLE)) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    // STATUS assembly and read-data mux; unmapped reads return 0.
    always_comb begin
        status    = '0;
        csr_rdata = '0;
        for (int i = 0; i < int'(NCHAN); i++) begin
            status[i]      = fresh[i];
            status[8 + i]  = out_val[i];
            status[16 + i] = fifo_full[i];
        end
        if (is_rd) begin
            if (req.num == CSR_STATUS) begin
                csr_rdata = status;
            end
`ifdef CSR_IO_CYCLE_COUNTER_EN
            if (req.num == CSR_CYCLE) begin
                csr_rdata = cycle_cnt;
            end
`endif
            for (int i = 0; i < int'(NCHAN); i++) begin
                if (rd_in_hit[i]) begin
                    csr_rdata = 32'(in_reg[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_csr_io_unit.sv
// Randomized self-checking bench for csr_io_unit against a queue-based reference model.
// Counter expectations follow CSR_IO_CYCLE_COUNTER_EN when defined.
module tb_csr_io_unit;

    localparam int NCH = 3;
    localparam int WD  = 32;
    localparam int DP  = 4;

    logic              clk;
    logic              rst;
    logic              csr_val;
    logic              csr_type;
    logic [11:0]       csr_num;
    logic [31:0]       csr_wdata;
    logic [31:0]       csr_rdata;
    logic              csr_stall;
    logic [NCH-1:0]    in_val;
    logic [NCH-1:0]    in_rdy;
    logic [NCH*WD-1:0] in_data;
    logic [NCH-1:0]    out_val;
    logic [NCH-1:0]    out_rdy;
    logic [NCH*WD-1:0] out_data;

    // Narrow instance for zero-extension and truncation checks.
    logic              c8_val;
    logic              c8_type;
    logic [11:0]       c8_num;
    logic [31:0]       c8_wdata;
    logic [31:0]       c8_rdata;
    logic              c8_stall;
    logic [NCH-1:0]    in8_val;
    logic [NCH-1:0]    in8_rdy;
    logic [NCH*8-1:0]  in8_data;
    logic [NCH-1:0]    out8_val;
    logic [NCH*8-1:0]  out8_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_reg   [NCH];
    bit          m_fresh [NCH];
    logic [31:0] m_q     [NCH][$];
    int unsigned m_cnt;

    csr_io_unit #(.NCHAN(NCH), .W(WD), .DEPTH(DP)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .csr_val   (csr_val),
        .csr_type  (csr_type),
        .csr_num   (csr_num),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .csr_stall (csr_stall),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_data  (out_data)
    );

    csr_io_unit #(.NCHAN(NCH), .W(8), .DEPTH(DP)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .csr_val   (c8_val),
        .csr_type  (c8_type),
        .csr_num   (c8_num),
        .csr_wdata (c8_wdata),
        .csr_rdata (c8_rdata),
        .csr_stall (c8_stall),
        .in_val    (in8_val),
        .in_rdy    (in8_rdy),
        .in_data   (in8_data),
        .out_val   (out8_val),
        .out_rdy   (3'b000),
        .out_data  (out8_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] num);
        logic [31:0] r;
        r = '0;
        if (num == 12'hFC1) begin
            for (int c = 0; c < NCH; c++) begin
                r[c]      = m_fresh[c];
                r[8 + c]  = (m_q[c].size() != 0);
                r[16 + c] = (m_q[c].size() == DP);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (num == 12'hFC2 + 12'(c)) r = m_reg[c];
        end
`ifdef CSR_IO_CYCLE_COUNTER_EN
        if (num == 12'hC00) r = m_cnt;
`endif
        return r;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_reg[c]   = '0;
            m_fresh[c] = 1'b0;
            m_q[c].delete();
        end
        m_cnt = 0;
    endtask

    task automatic set_csr(input bit v, input bit t, input logic [11:0] n, input logic [31:0] d);
        csr_val   = v;
        csr_type  = t;
        csr_num   = n;
        csr_wdata = d;
    endtask

    task automatic set_idle();
        set_csr(1'b0, 1'b0, 12'h000, 32'h0);
        in_val  = '0;
        out_rdy = '0;
    endtask

    // Called at a negedge with inputs set; checks combinational outputs, then advances the model.
    task automatic step();
        bit             rd;
        bit             wr;
        bit             exp_stall;
        logic [NCH-1:0] exp_rdy;
        #2;
        rd        = csr_val && !csr_type;
        wr        = csr_val && csr_type;
        exp_stall = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            exp_rdy[c] = !m_fresh[c] || (rd && csr_num == 12'hFC2 + 12'(c));
            if (wr && csr_num == 12'h7C2 + 12'(c) && m_q[c].size() == DP && !out_rdy[c])
                exp_stall = 1'b1;
            chk("out_val", 32'(out_val[c]), 32'(m_q[c].size() != 0));
            if (m_q[c].size() != 0) chk("out_data", out_data[c*WD +: WD], m_q[c][0]);
        end
        chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
        chk("csr_stall", 32'(csr_stall), 32'(exp_stall));
        if (rd) chk("csr_rdata", csr_rdata, model_read(csr_num));
        @(posedge clk);
        for (int c = 0; c < NCH; c++) begin
            if (m_q[c].size() != 0 && out_rdy[c]) void'(m_q[c].pop_front());
            if (wr && csr_num == 12'h7C2 + 12'(c) && !exp_stall) m_q[c].push_back(csr_wdata);
            if (in_val[c] && exp_rdy[c]) begin
                m_reg[c]   = in_data[c*WD +: WD];
                m_fresh[c] = 1'b1;
            end else if (rd && csr_num == 12'hFC2 + 12'(c)) begin
                m_fresh[c] = 1'b0;
            end
        end
        if (wr && csr_num == 12'hC00) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        @(negedge clk);
    endtask

    task automatic rand_inputs(input int rdy_pct);
        int unsigned sel;
        sel       = $urandom_range(0, 9);
        csr_val   = ($urandom_range(0, 3) != 0);
        csr_type  = $urandom_range(0, 1);
        csr_wdata = $urandom;
        case (sel)
            0, 1, 2: csr_num = 12'hFC2 + 12'(sel);
            3, 4, 5: csr_num = 12'h7C2 + 12'(sel - 3);
            6:       csr_num = 12'hFC1;
            7:       csr_num = ($urandom_range(0, 7) == 0) ? 12'hC00 : 12'hFC1;
            8:       csr_num = 12'hFC5;
            default: csr_num = 12'($urandom);
        endcase
        for (int c = 0; c < NCH; c++) begin
            in_val[c]  = $urandom_range(0, 1);
            out_rdy[c] = ($urandom_range(0, 99) < rdy_pct);
        end
        in_data = {$urandom, $urandom, $urandom};
    endtask

    // Asynchronous reset asserted mid-cycle with buffered data present.
    task automatic mid_reset();
        set_idle();
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_val", 32'(out_val), 32'h0);
        chk("rst_in_rdy", 32'(in_rdy), 32'h7);
        chk("rst_out_data", out_data[31:0], 32'h0);
        set_csr(1'b1, 1'b0, 12'hFC1, 32'h0);
        #1;
        chk("rst_status", csr_rdata, 32'h0);
        chk("rst_stall", 32'(csr_stall), 32'h0);
        model_clear();
        set_idle();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] drain [5];
        rst      = 1'b0;
        c8_val   = 1'b0;
        c8_type  = 1'b0;
        c8_num   = '0;
        c8_wdata = '0;
        in8_val  = '0;
        in8_data = '0;
        in_data  = '0;
        set_idle();
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Cycle counter: ten edges after reset release.
        repeat (10) step();
        set_csr(1'b1, 1'b0, 12'hC00, 32'h0);
        #1;
`ifdef CSR_IO_CYCLE_COUNTER_EN
        chk("t6_cnt10", csr_rdata, 32'd10);
        step();
        set_csr(1'b1, 1'b1, 12'hC00, 32'h0);
        step();
        set_csr(1'b1, 1'b0, 12'hC00, 32'h0);
        #1;
        chk("t6_cleared", csr_rdata, 32'd0);
`else
        chk("t6_unmapped", csr_rdata, 32'd0);
`endif
        step();

        // Input channel 1 capture, read, and fresh clear.
        set_idle();
        in_val[1] = 1'b1;
        in_data   = {32'h0, 32'h1234, 32'h0};
        step();
        set_idle();
        set_csr(1'b1, 1'b0, 12'hFC1, 32'h0);
        #1;
        chk("t2_status1", 32'(csr_rdata[1]), 32'h1);
        chk("t2_in_rdy1", 32'(in_rdy[1]), 32'h0);
        step();
        set_csr(1'b1, 1'b0, 12'hFC3, 32'h0);
        #1;
        chk("t2_read", csr_rdata, 32'h1234);
        step();
        set_csr(1'b1, 1'b0, 12'hFC1, 32'h0);
        #1;
        chk("t2_status1_clr", 32'(csr_rdata[1]), 32'h0);
        step();

        // Same-cycle read and transfer on channel 0.
        set_idle();
        in_val[0] = 1'b1;
        in_data   = {32'h0, 32'h0, 32'h11};
        step();
        set_csr(1'b1, 1'b0, 12'hFC2, 32'h0);
        in_data = {32'h0, 32'h0, 32'h55};
        #1;
        chk("t5_old", csr_rdata, 32'h11);
        step();
        set_idle();
        set_csr(1'b1, 1'b0, 12'hFC1, 32'h0);
        #1;
        chk("t5_fresh", 32'(csr_rdata[0]), 32'h1);
        step();
        set_csr(1'b1, 1'b0, 12'hFC2, 32'h0);
        #1;
        chk("t5_new", csr_rdata, 32'h55);
        step();

        // Output channel 0: fill, stall on fifth write, release with same-cycle pop.
        drain = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
        set_idle();
        for (int k = 0; k < 4; k++) begin
            set_csr(1'b1, 1'b1, 12'h7C2, drain[k]);
            step();
        end
        set_csr(1'b1, 1'b0, 12'hFC1, 32'h0);
        #1;
        chk("t3_full", 32'(csr_rdata[16]), 32'h1);
        step();
        set_csr(1'b1, 1'b1, 12'h7C2, drain[4]);
        #1;
        chk("t3_stall", 32'(csr_stall), 32'h1);
        step();
        out_rdy[0] = 1'b1;
        #1;
        chk("t3_release", 32'(csr_stall), 32'h0);
        chk("t3_head", out_data[31:0], drain[0]);
        step();
        set_idle();
        out_rdy[0] = 1'b1;
        for (int k = 1; k < 5; k++) begin
            #1;
            chk("t3_drain", out_data[31:0], drain[k]);
            step();
        end
        #1;
        chk("t3_empty", 32'(out_val[0]), 32'h0);
        step();

        // Random traffic, mostly back-pressured, then mid-run reset.
        for (int n = 0; n < 1500; n++) begin
            rand_inputs(25);
            step();
        end
        mid_reset();
        for (int n = 0; n < 1500; n++) begin
            rand_inputs(60);
            step();
        end

        // Narrow channel width: truncation on write, zero-extension on read.
        set_idle();
        c8_val      = 1'b1;
        c8_type     = 1'b1;
        c8_num      = 12'h7C4;
        c8_wdata    = 32'hFFFF_01AB;
        in8_val     = 3'b001;
        in8_data    = 24'h000080;
        @(negedge clk);
        c8_type  = 1'b0;
        c8_num   = 12'hFC2;
        in8_val  = '0;
        #1;
        chk("t4_out8_val", 32'(out8_val[2]), 32'h1);
        chk("t4_out8_data", 32'(out8_data[23:16]), 32'hAB);
        chk("t4_rd8", c8_rdata, 32'h0000_0080);
        @(negedge clk);
        c8_val = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
